// File: rtl/wave_ram_read_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wave_ram_read_arbiter: round-robin share of one wavetable RAM read port   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module wave_ram_read_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 11,
  parameter int BANK_W  = 2,
  parameter int DATA_W  = 16,
  parameter int RAM_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
  input  logic [NUM_REQ*BANK_W-1:0] i_req_bank,
  input  logic                      i_hold,
  output logic [NUM_REQ-1:0]        o_gnt,
  output logic                      o_ram_re,
  output logic [ADDR_W-1:0]         o_ram_addr,
  output logic [BANK_W-1:0]         o_ram_bank,
  input  logic [DATA_W-1:0]         i_ram_rdata,
  output logic [NUM_REQ-1:0]        o_rvalid,
  output logic [DATA_W-1:0]         o_rdata,
  output logic                      o_busy
);

  localparam int c_PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [c_PTR_W-1:0] r_ptr;
  logic [c_PTR_W-1:0] w_idx;
  logic [c_PTR_W-1:0] w_win;
  logic [c_PTR_W-1:0] w_ptr_nxt;
  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_win_oh;
  logic               w_any;
  logic               w_any_tag;

  logic [NUM_REQ-1:0] r_gnt;
  logic               r_re;
  logic [ADDR_W-1:0]  r_addr;
  logic [BANK_W-1:0]  r_bank;
  logic [NUM_REQ-1:0] r_tag [RAM_LAT];
  logic [NUM_REQ-1:0] r_rvalid;
  logic [DATA_W-1:0]  r_rdata;

  // A voice in its grant cycle may still show req; masking with r_gnt prevents a double grant.
  assign w_elig = i_req & ~r_gnt & {NUM_REQ{~i_hold}};
  assign w_any  = |w_elig;

  // Scan downward so the last hit is the first eligible index at or above r_ptr.
  always_comb begin
    w_win = '0;
    w_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = c_PTR_W'((int'(r_ptr) + k) % NUM_REQ);
      if (w_elig[w_idx]) begin
        w_win = w_idx;
      end
    end
  end

  assign w_win_oh  = NUM_REQ'(1) << w_win;
  assign w_ptr_nxt = (w_win == c_PTR_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;

  always_comb begin
    w_any_tag = 1'b0;
    for (int i = 0; i < RAM_LAT; i++) begin
      w_any_tag = w_any_tag | (|r_tag[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr    <= '0;
      r_gnt    <= '0;
      r_re     <= 1'b0;
      r_addr   <= '0;
      r_bank   <= '0;
      r_rvalid <= '0;
      r_rdata  <= '0;
      for (int i = 0; i < RAM_LAT; i++) begin
        r_tag[i] <= '0;
      end
    end else begin
      r_gnt <= w_any ? w_win_oh : '0;
      r_re  <= w_any;
      if (w_any) begin
        r_addr <= i_req_addr[w_win*ADDR_W +: ADDR_W];
        r_bank <= i_req_bank[w_win*BANK_W +: BANK_W];
        r_ptr  <= w_ptr_nxt;
      end
      // The tag follows the read through the RAM so the sample returns to its voice.
      r_tag[0] <= r_gnt;
      for (int i = 1; i < RAM_LAT; i++) begin
        r_tag[i] <= r_tag[i-1];
      end
      r_rvalid <= r_tag[RAM_LAT-1];
      if (|r_tag[RAM_LAT-1]) begin
        r_rdata <= i_ram_rdata;
      end
    end
  end

  assign o_gnt      = r_gnt;
  assign o_ram_re   = r_re;
  assign o_ram_addr = r_addr;
  assign o_ram_bank = r_bank;
  assign o_rvalid   = r_rvalid;
  assign o_rdata    = r_rdata;
  assign o_busy     = r_re | w_any_tag | (|r_rvalid);

endmodule
`default_nettype wire
